imem_stream_loader: RTL and testbench

//  Boot-time loader for the single-cycle RISC-V core. Accepts a byte stream (valid/ready),

---
 rtl/imem_stream_loader.sv | 108 ++++++++++
 tb/tb_imem_stream_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_stream_loader.sv
// Boot loader: assembles a byte stream into little-endian 32-bit words, writes them to
// instruction memory and releases the core only after the image checksum matches.
module imem_stream_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic        xfer;
  logic        restart;
  logic        cnt_bad;
  logic        last_addr;
  logic [7:0]  cnt_lo;
  logic [15:0] cnt;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [7:0]  csum;

  assign xfer      = in_valid & in_ready;
  assign restart   = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
  assign cnt_bad   = ({in_data, cnt_lo} == 16'd0) ||
                     (32'({in_data, cnt_lo}) > 32'(MAX_WORDS));
  assign last_addr = (32'(mem_addr) == (32'(cnt) - 32'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_HDR0;
      S_HDR0: if (xfer) state_nxt = S_HDR1;
      S_HDR1: if (xfer) state_nxt = cnt_bad ? S_ERR : S_DATA;
      // The strobe for the final word lands in CSUM, so the checksum byte may follow at once
      S_DATA: if (xfer && (byte_idx == 2'd3) && last_addr) state_nxt = S_CSUM;
      S_CSUM: if (xfer) state_nxt = (in_data == csum) ? S_DONE : S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == S_HDR0) | (state == S_HDR1) | (state == S_DATA) | (state == S_CSUM);
    in_ready   = busy;
    done       = (state == S_DONE);
    error      = (state == S_ERR);
    core_reset = (state != S_DONE);
  end

  // Byte assembly stage -> memory write stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt_lo    <= '0;
      cnt       <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      csum      <= '0;
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        csum     <= '0;
        byte_idx <= '0;
        mem_addr <= '0;
      end
      if ((state == S_HDR0) && xfer) cnt_lo <= in_data;
      if ((state == S_HDR1) && xfer) begin
        cnt      <= {in_data, cnt_lo};
        mem_addr <= '0;
        byte_idx <= '0;
        csum     <= '0;
      end
      if ((state == S_DATA) && xfer) begin
        byte_idx <= byte_idx + 2'd1;
        csum     <= csum ^ in_data;
        word_buf <= {in_data, word_buf[23:8]};
        if (byte_idx == 2'd3) begin
          mem_we    <= 1'b1;
          mem_wdata <= {in_data, word_buf};
        end
      end
      // Hold the address on the final word so it never passes N-1
      if (mem_we && !last_addr) mem_addr <= mem_addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Scoreboard bench for imem_stream_loader: expected writes are queued while frames are
// driven and compared against the writes captured from the memory port.
module tb_imem_stream_loader;
  localparam int ADDR_W    = 8;
  localparam int MAX_WORDS = 256;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready, mem_we, core_reset, busy, done, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  typedef logic [39:0] wr_t;
  wr_t         exp_q[$];
  wr_t         got_q[$];
  logic [31:0] words[$];
  int          got_rd = 0;
  int          tests = 0;
  int          fails = 0;

  imem_stream_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_reset(core_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (reset && mem_we) got_q.push_back({mem_addr, mem_wdata});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input string tag);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && k < 20) begin @(posedge clk); #1; k++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL %s ready_timeout: in_ready=%b required 1", tag, in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Sends header, data bytes of `words` and XOR checksum (^cmask); stop>=0 aborts after that many data bytes
  task automatic send_frame(input logic [15:0] n, input logic [7:0] cmask, input int gap,
                            input bit poke, input int stop, input string tag);
    logic [7:0]  x, b;
    logic [31:0] w;
    x = 8'h00;
    send_byte(n[7:0], tag);
    send_byte(n[15:8], tag);
    for (int i = 0; i < words.size() * 4; i++) begin
      if (stop >= 0 && i >= stop) return;
      for (int g = 0; g < gap; g++) begin
        start = poke && (i == 5) && (g == 0);
        @(posedge clk); #1;
        start = 1'b0;
      end
      w = words[i / 4];
      b = w[8 * (i % 4) +: 8];
      x = x ^ b;
      send_byte(b, tag);
      if (i % 4 == 3) exp_q.push_back({8'(i / 4), w});
    end
    send_byte(x ^ cmask, tag);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({core_reset, in_ready, mem_we, done, error, busy} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_flags: core_reset/in_ready/mem_we/done/error/busy=%b required 100000",
               {core_reset, in_ready, mem_we, done, error, busy});
    end
    tests++;
    if (mem_addr !== 8'd0 || mem_wdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_mem: addr=%h wdata=%h required 00 00000000", mem_addr, mem_wdata);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (core_reset !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: core_reset=%b busy=%b required 1 0", core_reset, busy);
    end
  endtask

  task automatic test_load_n2();
    words = '{32'h00500513, 32'h00A00593};
    pulse_start();
    tests++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL load_busy: busy=%b in_ready=%b required 1 1", busy, in_ready);
    end
    send_frame(16'd2, 8'h00, 0, 1'b0, -1, "load");
    tests++;
    if ({done, error, core_reset, busy, in_ready} !== 5'b10000) begin
      fails++;
      $display("FAIL load_done: done/error/core_reset/busy/in_ready=%b required 10000",
               {done, error, core_reset, busy, in_ready});
    end
    tests++;
    if (mem_addr !== 8'd1) begin
      fails++; $display("FAIL load_last_addr: got %0d required 1", mem_addr);
    end
    tests++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      fails++; $display("FAIL load_write_count: got %0d required %0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() != 0 && got_rd < got_q.size()) begin
      tests++;
      if (got_q[got_rd] !== exp_q[0]) begin
        fails++; $display("FAIL load_write: got %h required %h", got_q[got_rd], exp_q[0]);
      end
      void'(exp_q.pop_front()); got_rd++;
    end
    exp_q.delete(); got_rd = got_q.size();
  endtask

  task automatic test_bad_csum();
    pulse_start();
    tests++;
    if (done !== 1'b0 || core_reset !== 1'b1) begin
      fails++; $display("FAIL restart_from_done: done=%b core_reset=%b required 0 1", done, core_reset);
    end
    send_frame(16'd2, 8'h70, 0, 1'b0, -1, "bad_csum");
    tests++;
    if ({error, done, core_reset, busy} !== 4'b1010) begin
      fails++;
      $display("FAIL bad_csum_err: error/done/core_reset/busy=%b required 1010", {error, done, core_reset, busy});
    end
    pulse_start();
    tests++;
    if (error !== 1'b0 || core_reset !== 1'b1) begin
      fails++; $display("FAIL restart_from_err: error=%b core_reset=%b required 0 1", error, core_reset);
    end
    send_frame(16'd2, 8'h00, 0, 1'b0, -1, "reload");
    tests++;
    if (done !== 1'b1 || core_reset !== 1'b0) begin
      fails++; $display("FAIL reload_done: done=%b core_reset=%b required 1 0", done, core_reset);
    end
    tests++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      fails++; $display("FAIL bad_csum_write_count: got %0d required %0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() != 0 && got_rd < got_q.size()) begin
      tests++;
      if (got_q[got_rd] !== exp_q[0]) begin
        fails++; $display("FAIL bad_csum_write: got %h required %h", got_q[got_rd], exp_q[0]);
      end
      void'(exp_q.pop_front()); got_rd++;
    end
    exp_q.delete(); got_rd = got_q.size();
  endtask

  task automatic test_bad_count();
    pulse_start();
    send_byte(8'h00, "cnt_zero");
    send_byte(8'h00, "cnt_zero");
    tests++;
    if ({error, in_ready, core_reset, done} !== 4'b1010) begin
      fails++;
      $display("FAIL cnt_zero: error/in_ready/core_reset/done=%b required 1010", {error, in_ready, core_reset, done});
    end
    pulse_start();
    send_byte(8'h01, "cnt_over");
    send_byte(8'h01, "cnt_over");
    tests++;
    if ({error, in_ready, core_reset, done} !== 4'b1010) begin
      fails++;
      $display("FAIL cnt_over: error/in_ready/core_reset/done=%b required 1010", {error, in_ready, core_reset, done});
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (got_q.size() != got_rd) begin
      fails++; $display("FAIL bad_count_writes: got %0d writes required 0", got_q.size() - got_rd);
    end
    got_rd = got_q.size();
  endtask

  task automatic test_max_words();
    words.delete();
    for (int i = 0; i < MAX_WORDS; i++) words.push_back($urandom);
    pulse_start();
    send_frame(16'(MAX_WORDS), 8'h00, 0, 1'b0, -1, "max");
    tests++;
    if (done !== 1'b1 || mem_addr !== 8'd255) begin
      fails++; $display("FAIL max_done: done=%b addr=%0d required 1 255", done, mem_addr);
    end
    tests++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      fails++; $display("FAIL max_write_count: got %0d required %0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() != 0 && got_rd < got_q.size()) begin
      tests++;
      if (got_q[got_rd] !== exp_q[0]) begin
        fails++; $display("FAIL max_write: got %h required %h", got_q[got_rd], exp_q[0]);
      end
      void'(exp_q.pop_front()); got_rd++;
    end
    exp_q.delete(); got_rd = got_q.size();
  endtask

  task automatic test_flow();
    words = '{32'h00500513, 32'h00A00593};
    pulse_start();
    send_frame(16'd2, 8'h00, 2, 1'b1, -1, "flow");
    tests++;
    if (done !== 1'b1 || core_reset !== 1'b0 || mem_addr !== 8'd1) begin
      fails++;
      $display("FAIL flow_done: done=%b core_reset=%b addr=%0d required 1 0 1", done, core_reset, mem_addr);
    end
    tests++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      fails++; $display("FAIL flow_write_count: got %0d required %0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() != 0 && got_rd < got_q.size()) begin
      tests++;
      if (got_q[got_rd] !== exp_q[0]) begin
        fails++; $display("FAIL flow_write: got %h required %h", got_q[got_rd], exp_q[0]);
      end
      void'(exp_q.pop_front()); got_rd++;
    end
    exp_q.delete(); got_rd = got_q.size();
  endtask

  task automatic test_reset_mid();
    words = '{32'h00500513, 32'h00A00593};
    pulse_start();
    send_frame(16'd2, 8'h00, 0, 1'b0, 5, "rst_mid");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({core_reset, in_ready, busy, mem_we, done, error} !== 6'b100000 || mem_addr !== 8'd0) begin
      fails++;
      $display("FAIL rst_mid_idle: core_reset/in_ready/busy/mem_we/done/error=%b addr=%0d required 100000 0",
               {core_reset, in_ready, busy, mem_we, done, error}, mem_addr);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    send_frame(16'd2, 8'h00, 0, 1'b0, -1, "rst_reload");
    tests++;
    if (done !== 1'b1 || core_reset !== 1'b0) begin
      fails++; $display("FAIL rst_reload_done: done=%b core_reset=%b required 1 0", done, core_reset);
    end
    tests++;
    if (got_q.size() - got_rd != exp_q.size()) begin
      fails++; $display("FAIL rst_write_count: got %0d required %0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() != 0 && got_rd < got_q.size()) begin
      tests++;
      if (got_q[got_rd] !== exp_q[0]) begin
        fails++; $display("FAIL rst_write: got %h required %h", got_q[got_rd], exp_q[0]);
      end
      void'(exp_q.pop_front()); got_rd++;
    end
    exp_q.delete(); got_rd = got_q.size();
  endtask

  initial begin
    test_reset();
    test_load_n2();
    test_bad_csum();
    test_bad_count();
    test_max_words();
    test_flow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
